// File: rtl/div_iter.sv
// div_iter: iterative radix-2 restoring divider for DIV/DIVU in the execute stage.
// One quotient bit per cycle over 32 cycles, then a single DONE cycle that presents the
// sign-corrected {HI = remainder, LO = quotient}.
//
// Ports:
//   clk        rising-edge clock
//   rst        synchronous active-high reset
//   start      DIV/DIVU present in E (held while the pipeline is stalled)
//   signed_div 1 = DIV (two's complement), 0 = DIVU; sampled on accept
//   a, b       dividend / divisor, sampled on accept
//   annul      cancel request from an exception flush
//   stall_div  combinational; high while the divider owns the E stage
//   ready      high during the DONE cycle, result valid
//   result     registered {remainder, quotient}
module div_iter (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic        signed_div,
  input  logic [31:0] a,
  input  logic [31:0] b,
  input  logic        annul,
  output logic        stall_div,
  output logic        ready,
  output logic [63:0] result
);

  typedef enum logic [1:0] {StIdle, StBusy, StDone} state_e;

  state_e      state_q, state_d;
  logic [4:0]  cnt_q;
  logic [31:0] rem_q;
  logic [31:0] quo_q;
  logic [31:0] dvs_q;
  logic        neg_quo_q;
  logic        neg_rem_q;

  logic        accept;
  logic [31:0] abs_a;
  logic [31:0] abs_b;
  logic [32:0] rem_sh;
  logic [31:0] quo_sh;
  logic [32:0] diff;
  logic [31:0] rem_nxt;
  logic [31:0] quo_nxt;
  logic [31:0] quo_fix;
  logic [31:0] rem_fix;

  assign accept = (state_q == StIdle) && start && !annul;

  // Magnitudes; -0x8000_0000 wraps to 0x8000_0000, which is the correct unsigned magnitude.
  assign abs_a = (signed_div && a[31]) ? -a : a;
  assign abs_b = (signed_div && b[31]) ? -b : b;

  // One restoring step: shift {rem, quo} left, trial-subtract, keep if non-negative.
  assign rem_sh  = {rem_q, quo_q[31]};
  assign quo_sh  = {quo_q[30:0], 1'b0};
  assign diff    = rem_sh - {1'b0, dvs_q};
  assign rem_nxt = diff[32] ? rem_sh[31:0] : diff[31:0];
  assign quo_nxt = diff[32] ? quo_sh : (quo_sh | 32'd1);

  assign quo_fix = neg_quo_q ? -quo_nxt : quo_nxt;
  assign rem_fix = neg_rem_q ? -rem_nxt : rem_nxt;

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle: begin
        if (accept) state_d = (b == 32'd0) ? StDone : StBusy;
      end
      StBusy: begin
        if (cnt_q == 5'd31) state_d = StDone;
      end
      StDone: state_d = StIdle;
      default: state_d = StIdle;
    endcase
    if (annul) state_d = StIdle;
  end

  always_comb begin
    stall_div = !annul && (((state_q == StIdle) && start) || (state_q == StBusy));
    ready     = !annul && (state_q == StDone);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= StIdle;
      cnt_q     <= 5'd0;
      rem_q     <= 32'd0;
      quo_q     <= 32'd0;
      dvs_q     <= 32'd0;
      neg_quo_q <= 1'b0;
      neg_rem_q <= 1'b0;
      result    <= 64'd0;
    end else begin
      state_q <= state_d;
      if (accept) begin
        if (b == 32'd0) begin
          // Divide by zero does not trap: HI = dividend, LO = all ones.
          result <= {a, 32'hFFFF_FFFF};
        end else begin
          cnt_q     <= 5'd0;
          rem_q     <= 32'd0;
          quo_q     <= abs_a;
          dvs_q     <= abs_b;
          neg_quo_q <= signed_div && (a[31] ^ b[31]);
          neg_rem_q <= signed_div && a[31];
        end
      end else if ((state_q == StBusy) && !annul) begin
        rem_q <= rem_nxt;
        quo_q <= quo_nxt;
        cnt_q <= cnt_q + 5'd1;
        // Final step feeds the corrected result straight into the register so it is
        // valid for the whole DONE cycle.
        if (cnt_q == 5'd31) result <= {rem_fix, quo_fix};
      end
    end
  end

endmodule

// File: tb/tb_div_iter.sv
module tb_div_iter;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic        signed_div;
  logic [31:0] a;
  logic [31:0] b;
  logic        annul;
  logic        stall_div;
  logic        ready;
  logic [63:0] result;

  int n_checks = 0;
  int n_fail   = 0;

  div_iter dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .signed_div(signed_div),
    .a         (a),
    .b         (b),
    .annul     (annul),
    .stall_div (stall_div),
    .ready     (ready),
    .result    (result)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Starts at a drive point (1 unit after a rising edge), ends at the next such point with
  // the divider back in IDLE. exp_lat is the cycle index of ready relative to accept.
  task automatic do_div(input string tag, input logic sg, input logic [31:0] av,
                        input logic [31:0] bv, input logic [63:0] exp, input int exp_lat);
    int stalls;
    int lat;
    stalls = 0;
    lat    = -1;
    start  = 1'b1;
    signed_div = sg;
    a = av;
    b = bv;
    for (int i = 0; i < 100; i++) begin
      #1;
      if (stall_div) stalls++;
      if (ready) begin
        lat   = i;
        start = 1'b0;
        chk({tag, "_result"}, result, exp);
        break;
      end
      // Operand changes after accept must be ignored.
      if (i == 1) begin
        a = ~av;
        b = 32'h3;
        signed_div = ~sg;
      end
      @(posedge clk);
      #1;
    end
    start = 1'b0;
    chk({tag, "_latency"}, 64'(lat), 64'(exp_lat));
    chk({tag, "_stall_cycles"}, 64'(stalls), 64'(exp_lat));
    @(posedge clk);
    #1;
    chk({tag, "_idle_ready"}, {63'd0, ready}, 64'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1);
  end

  initial begin
    int stalls;
    int r1;
    int r2;
    logic seen;

    rst = 1'b1;
    start = 1'b0;
    signed_div = 1'b0;
    a = 32'd0;
    b = 32'd0;
    annul = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    #1;
    chk("reset_result", result, 64'd0);
    chk("reset_ready", {63'd0, ready}, 64'd0);
    chk("reset_stall", {63'd0, stall_div}, 64'd0);
    @(posedge clk);
    #1;

    do_div("divu_100_7", 1'b0, 32'd100, 32'd7, {32'd2, 32'd14}, 33);
    do_div("div_m7_2", 1'b1, 32'hFFFF_FFF9, 32'd2, {32'hFFFF_FFFF, 32'hFFFF_FFFD}, 33);
    do_div("div_7_m2", 1'b1, 32'd7, 32'hFFFF_FFFE, {32'h0000_0001, 32'hFFFF_FFFD}, 33);
    do_div("div_m100_m7", 1'b1, 32'hFFFF_FF9C, 32'hFFFF_FFF9, {32'hFFFF_FFFE, 32'd14}, 33);
    do_div("div_ovf", 1'b1, 32'h8000_0000, 32'hFFFF_FFFF, {32'd0, 32'h8000_0000}, 33);
    do_div("divu_max_1", 1'b0, 32'hFFFF_FFFF, 32'd1, {32'd0, 32'hFFFF_FFFF}, 33);
    do_div("divu_5_0", 1'b0, 32'd5, 32'd0, {32'd5, 32'hFFFF_FFFF}, 1);

    // Annul mid-operation: result must keep {5, FFFF_FFFF}.
    start = 1'b1;
    signed_div = 1'b0;
    a = 32'd100;
    b = 32'd7;
    repeat (10) begin
      @(posedge clk);
      #1;
    end
    annul = 1'b1;
    start = 1'b0;
    #1;
    chk("annul_stall_same_cycle", {63'd0, stall_div}, 64'd0);
    seen = ready;
    @(posedge clk);
    #1;
    annul = 1'b0;
    #1;
    seen = seen | ready;
    chk("annul_idle_stall", {63'd0, stall_div}, 64'd0);
    chk("annul_result_kept", result, {32'd5, 32'hFFFF_FFFF});
    @(posedge clk);
    #1;
    seen = seen | ready;
    chk("annul_no_ready", {63'd0, seen}, 64'd0);
    chk("annul_result_kept2", result, {32'd5, 32'hFFFF_FFFF});
    do_div("annul_restart", 1'b0, 32'd100, 32'd7, {32'd2, 32'd14}, 33);

    // Back-to-back with start held throughout.
    start = 1'b1;
    signed_div = 1'b0;
    a = 32'd9;
    b = 32'd3;
    stalls = 0;
    r1 = -1;
    r2 = -1;
    for (int i = 0; i < 120; i++) begin
      #1;
      if (stall_div) stalls++;
      if (ready) begin
        chk("b2b_stall_in_done", {63'd0, stall_div}, 64'd0);
        if (r1 < 0) begin
          r1 = i;
          chk("b2b_first_result", result, {32'd0, 32'd3});
          a = 32'd10;
          b = 32'd4;
        end else begin
          r2 = i;
          chk("b2b_second_result", result, {32'd2, 32'd2});
          start = 1'b0;
          break;
        end
      end
      @(posedge clk);
      #1;
    end
    start = 1'b0;
    chk("b2b_first_latency", 64'(r1), 64'd33);
    chk("b2b_second_latency", 64'(r2), 64'd67);
    chk("b2b_stall_cycles", 64'(stalls), 64'd66);
    @(posedge clk);
    #1;

    // Synchronous reset in the middle of BUSY.
    start = 1'b1;
    signed_div = 1'b0;
    a = 32'd100;
    b = 32'd7;
    repeat (5) begin
      @(posedge clk);
      #1;
    end
    rst = 1'b1;
    start = 1'b0;
    @(posedge clk);
    #1;
    rst = 1'b0;
    #1;
    chk("rst_mid_result", result, 64'd0);
    chk("rst_mid_ready", {63'd0, ready}, 64'd0);
    chk("rst_mid_stall", {63'd0, stall_div}, 64'd0);
    @(posedge clk);
    #1;
    do_div("after_rst", 1'b0, 32'd100, 32'd7, {32'd2, 32'd14}, 33);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
